// File: rtl/imem_dmem_arbiter.sv
// imem_dmem_arbiter
//   Shares one single-port synchronous word memory between instruction fetch
//   and the data (load/store) port. At most one grant per cycle. The data side
//   wins conflicts. An anti-starvation counter forces fetch through after
//   STARVE_MAX consecutive data-won conflicts. Read data returns one cycle
//   after grant.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   if_req/if_addr             fetch request (read only), byte address
//   if_gnt                     fetch accepted this cycle (combinational)
//   if_rvalid/if_rdata         fetch response, one cycle after if_gnt
//   d_req/d_we/d_be/d_addr/d_wdata  data request (load or store)
//   d_gnt                      data accepted this cycle (combinational)
//   d_rvalid/d_rdata           load response, one cycle after d_gnt
//   stall_if                   fetch is waiting (if_req & ~if_gnt)
//   conflict_cnt               saturating count of if_req & d_req cycles
//   mem_en/mem_we/mem_be/mem_addr/mem_wdata  memory macro drive
//   mem_rdata                  memory read data, valid the cycle after a read
module imem_dmem_arbiter #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              stall_if,
  output logic [15:0]       conflict_cnt,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  // Counter is at least one bit wide so STARVE_MAX=0 still elaborates.
  localparam int unsigned    SW         = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0]  STARVE_LIM = SW'(STARVE_MAX);
  localparam bit             STARVE_EN  = (STARVE_MAX != 0);

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_IF   = 2'd1,
    RESP_DRD  = 2'd2
  } resp_e;

  resp_e          r_resp_owner;
  resp_e          w_resp_nxt;
  logic [SW-1:0]  r_starve_cnt;
  logic [SW-1:0]  w_starve_nxt;
  logic [15:0]    r_conflict_cnt;
  logic           w_both;
  logic           w_force_if;
  logic           w_unused;

  // Byte-offset bits and bits above the word index are deliberately dropped.
  assign w_unused = ^{if_addr[1:0], if_addr[31:ADDR_W+2], d_addr[1:0], d_addr[31:ADDR_W+2]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp_owner   <= RESP_NONE;
      r_starve_cnt   <= '0;
      r_conflict_cnt <= '0;
    end else begin
      r_resp_owner <= w_resp_nxt;
      r_starve_cnt <= w_starve_nxt;
      if (w_both && (r_conflict_cnt != '1)) begin
        r_conflict_cnt <= r_conflict_cnt + 16'd1;
      end
    end
  end

  always_comb begin
    w_both       = if_req & d_req;
    w_force_if   = STARVE_EN && (r_starve_cnt == STARVE_LIM);
    if_gnt       = if_req & (~d_req | w_force_if);
    d_gnt        = d_req & ~(if_req & w_force_if);
    stall_if     = if_req & ~if_gnt;

    w_resp_nxt   = RESP_NONE;
    if (if_gnt) begin
      w_resp_nxt = RESP_IF;
    end else if (d_gnt && !d_we) begin
      w_resp_nxt = RESP_DRD;
    end

    // Cleared whenever fetch is served or not asking; saturates at the limit
    // so the forced fetch grant is the only way out of the top value.
    w_starve_nxt = r_starve_cnt;
    if (!if_req || if_gnt) begin
      w_starve_nxt = '0;
    end else if (STARVE_EN && w_both && d_gnt && (r_starve_cnt != STARVE_LIM)) begin
      w_starve_nxt = r_starve_cnt + 1'b1;
    end

    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (if_gnt) begin
      mem_en   = 1'b1;
      mem_be   = '1;
      mem_addr = if_addr[ADDR_W+1:2];
    end else if (d_gnt) begin
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_be    = d_we ? d_be : 4'hF;
      mem_addr  = d_addr[ADDR_W+1:2];
      mem_wdata = d_we ? d_wdata : '0;
    end
  end

  assign if_rvalid    = (r_resp_owner == RESP_IF);
  assign d_rvalid     = (r_resp_owner == RESP_DRD);
  assign if_rdata     = if_rvalid ? mem_rdata : '0;
  assign d_rdata      = d_rvalid  ? mem_rdata : '0;
  assign conflict_cnt = r_conflict_cnt;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
module tb_imem_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  // Main DUT (STARVE_MAX=4)
  logic        if_req, if_gnt, if_rvalid, d_req, d_we, d_gnt, d_rvalid, stall_if;
  logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata, mem_wdata, mem_rdata;
  logic [3:0]  d_be, mem_be;
  logic [15:0] conflict_cnt;
  logic        mem_en, mem_we;
  logic [9:0]  mem_addr;

  // Strict-priority DUT (STARVE_MAX=0)
  logic        if_req_z, if_gnt_z, if_rvalid_z, d_req_z, d_gnt_z, d_rvalid_z, stall_if_z;
  logic [31:0] if_rdata_z, d_rdata_z, mem_wdata_z, mem_rdata_z;
  logic [3:0]  mem_be_z;
  logic [15:0] conflict_cnt_z;
  logic        mem_en_z, mem_we_z;
  logic [9:0]  mem_addr_z;

  int vectors    = 0;
  int miscompares = 0;

  imem_dmem_arbiter #(.ADDR_W(10), .STARVE_MAX(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .stall_if(stall_if), .conflict_cnt(conflict_cnt),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  imem_dmem_arbiter #(.ADDR_W(10), .STARVE_MAX(0)) u_dut_strict (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req_z), .if_addr(32'h0), .if_gnt(if_gnt_z),
    .if_rvalid(if_rvalid_z), .if_rdata(if_rdata_z),
    .d_req(d_req_z), .d_we(1'b0), .d_be(4'h0), .d_addr(32'h40), .d_wdata(32'h0),
    .d_gnt(d_gnt_z), .d_rvalid(d_rvalid_z), .d_rdata(d_rdata_z),
    .stall_if(stall_if_z), .conflict_cnt(conflict_cnt_z),
    .mem_en(mem_en_z), .mem_we(mem_we_z), .mem_be(mem_be_z), .mem_addr(mem_addr_z),
    .mem_wdata(mem_wdata_z), .mem_rdata(mem_rdata_z)
  );

  assign mem_rdata_z = 32'h0;

  // Synchronous single-port memory model with byte write enables.
  logic [31:0] mem [0:1023];
  logic [31:0] mem_q;
  logic        mem_ready = 1'b0;
  assign mem_rdata = mem_q;

  always @(posedge clk) begin
    if (!mem_ready) begin
      mem[0]    <= 32'h13;
      mem[1]    <= 32'h93;
      mem[2]    <= 32'h113;
      mem_ready <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_q <= mem[mem_addr];
      end
    end
  end

  task automatic idle_inputs();
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
    if_req_z = 1'b0; d_req_z = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (3) @(negedge clk);
    #1;
    vectors++;
    if ({if_rvalid, d_rvalid} !== 2'b00) begin
      miscompares++; $display("FAIL reset_rvalid got %b exp 00", {if_rvalid, d_rvalid});
    end
    vectors++;
    if ({if_rdata, d_rdata} !== 64'h0) begin
      miscompares++; $display("FAIL reset_rdata got %h exp 0", {if_rdata, d_rdata});
    end
    vectors++;
    if (conflict_cnt !== 16'h0) begin
      miscompares++; $display("FAIL reset_conflict got %h exp 0000", conflict_cnt);
    end
    vectors++;
    if ({if_gnt, d_gnt, mem_en, mem_we, stall_if} !== 5'b0) begin
      miscompares++; $display("FAIL reset_idle got %b exp 00000", {if_gnt, d_gnt, mem_en, mem_we, stall_if});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_fetch_only();
    logic [31:0] exp_d [3];
    logic        exp_v;
    logic [31:0] exp_r;
    exp_d[0] = 32'h13; exp_d[1] = 32'h93; exp_d[2] = 32'h113;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i < 3) begin if_req = 1'b1; if_addr = 32'(i * 4); end
      else if_req = 1'b0;
      #1;
      if (i < 3) begin
        vectors++;
        if ({if_gnt, d_gnt, stall_if} !== 3'b100) begin
          miscompares++; $display("FAIL fetch_gnt[%0d] got %b exp 100", i, {if_gnt, d_gnt, stall_if});
        end
        vectors++;
        if (mem_addr !== 10'(i) || mem_en !== 1'b1 || mem_we !== 1'b0) begin
          miscompares++; $display("FAIL fetch_mem[%0d] got addr %h en %b we %b exp addr %h en 1 we 0", i, mem_addr, mem_en, mem_we, i);
        end
      end
      exp_v = (i >= 1 && i <= 3);
      exp_r = exp_v ? exp_d[i-1] : 32'h0;
      vectors++;
      if (if_rvalid !== exp_v || if_rdata !== exp_r) begin
        miscompares++; $display("FAIL fetch_resp[%0d] got v%b %h exp v%b %h", i, if_rvalid, if_rdata, exp_v, exp_r);
      end
    end
  endtask

  task automatic test_store_load();
    logic        we [4];
    logic [3:0]  be [4];
    logic [31:0] wd [4];
    logic        exp_v;
    logic [31:0] exp_r;
    we[0] = 1; be[0] = 4'hF;    wd[0] = 32'hDEADBEEF;
    we[1] = 0; be[1] = 4'hF;    wd[1] = 32'h0;
    we[2] = 1; be[2] = 4'b0010; wd[2] = 32'h0000AA00;
    we[3] = 0; be[3] = 4'hF;    wd[3] = 32'h0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i < 4) begin
        d_req = 1'b1; d_we = we[i]; d_be = be[i]; d_addr = 32'h40; d_wdata = wd[i];
      end else d_req = 1'b0;
      #1;
      if (i < 4) begin
        vectors++;
        if (d_gnt !== 1'b1 || if_gnt !== 1'b0 || mem_addr !== 10'h010 || mem_we !== we[i]) begin
          miscompares++; $display("FAIL ls_mem[%0d] got gnt %b addr %h we %b exp gnt 1 addr 010 we %b", i, d_gnt, mem_addr, mem_we, we[i]);
        end
        vectors++;
        if (mem_be !== be[i] || mem_wdata !== wd[i]) begin
          miscompares++; $display("FAIL ls_be_wd[%0d] got %h %h exp %h %h", i, mem_be, mem_wdata, be[i], wd[i]);
        end
      end
      exp_v = (i == 2 || i == 4);
      exp_r = (i == 2) ? 32'hDEADBEEF : (i == 4) ? 32'hDEADAAEF : 32'h0;
      vectors++;
      if (d_rvalid !== exp_v || d_rdata !== exp_r || if_rvalid !== 1'b0) begin
        miscompares++; $display("FAIL ls_resp[%0d] got v%b %h ifv%b exp v%b %h ifv0", i, d_rvalid, d_rdata, if_rvalid, exp_v, exp_r);
      end
    end
  endtask

  task automatic test_conflict();
    logic exp_i;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if_req = 1'b1; if_addr = 32'h0;
      d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h40;
      #1;
      exp_i = (i == 4 || i == 9);
      vectors++;
      if ({if_gnt, d_gnt, stall_if} !== {exp_i, ~exp_i, ~exp_i}) begin
        miscompares++; $display("FAIL conflict_gnt[%0d] got %b exp %b", i, {if_gnt, d_gnt, stall_if}, {exp_i, ~exp_i, ~exp_i});
      end
    end
    @(negedge clk);
    idle_inputs();
    #1;
    vectors++;
    if (conflict_cnt !== 16'd10) begin
      miscompares++; $display("FAIL conflict_cnt got %0d exp 10", conflict_cnt);
    end
  endtask

  task automatic test_strict_priority();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if_req_z = 1'b1; d_req_z = 1'b1;
      #1;
      vectors++;
      if ({if_gnt_z, d_gnt_z, stall_if_z} !== 3'b011) begin
        miscompares++; $display("FAIL strict_gnt[%0d] got %b exp 011", i, {if_gnt_z, d_gnt_z, stall_if_z});
      end
    end
    @(negedge clk);
    idle_inputs();
    #1;
    vectors++;
    if (conflict_cnt_z !== 16'd8) begin
      miscompares++; $display("FAIL strict_cnt got %0d exp 8", conflict_cnt_z);
    end
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h0; d_req = 1'b1; d_addr = 32'h40;
    @(negedge clk);
    d_req = 1'b0;
    #1;
    vectors++;
    if (if_gnt !== 1'b1) begin
      miscompares++; $display("FAIL midrst_gnt got %b exp 1", if_gnt);
    end
    #1;
    rst_n = 1'b0;
    if_req = 1'b0;
    @(negedge clk);
    #1;
    vectors++;
    if (if_rvalid !== 1'b0 || if_rdata !== 32'h0 || d_rvalid !== 1'b0) begin
      miscompares++; $display("FAIL midrst_rvalid got %b %h %b exp 0 0 0", if_rvalid, if_rdata, d_rvalid);
    end
    vectors++;
    if (conflict_cnt !== 16'h0) begin
      miscompares++; $display("FAIL midrst_cnt got %h exp 0000", conflict_cnt);
    end
    rst_n = 1'b1;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h8;
    #1;
    vectors++;
    if (if_gnt !== 1'b1 || if_rvalid !== 1'b0) begin
      miscompares++; $display("FAIL postrst_gnt got gnt %b v %b exp gnt 1 v 0", if_gnt, if_rvalid);
    end
    @(negedge clk);
    if_req = 1'b0;
    #1;
    vectors++;
    if (if_rvalid !== 1'b1 || if_rdata !== 32'h113) begin
      miscompares++; $display("FAIL postrst_resp got v%b %h exp v1 00000113", if_rvalid, if_rdata);
    end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    idle_inputs();
    if_req = 1'b1; if_addr = 32'h1004;
    #1;
    vectors++;
    if (mem_addr !== 10'h001 || mem_be !== 4'hF) begin
      miscompares++; $display("FAIL wrap_if got %h %h exp 001 f", mem_addr, mem_be);
    end
    @(negedge clk);
    if_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_be = 4'h3; d_addr = 32'hFFFF_FFFE;
    #1;
    vectors++;
    if (mem_addr !== 10'h3FF || mem_be !== 4'hF || mem_we !== 1'b0) begin
      miscompares++; $display("FAIL wrap_d got %h %h %b exp 3ff f 0", mem_addr, mem_be, mem_we);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_saturation();
    do_reset();
    for (int n = 0; n < 65540; n++) begin
      @(negedge clk);
      if_req = 1'b1; if_addr = 32'h0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
      if (n == 65534 || n == 65535) begin
        #1;
        vectors++;
        if (conflict_cnt !== 16'(n)) begin
          miscompares++; $display("FAIL sat_edge[%0d] got %h exp %h", n, conflict_cnt, 16'(n));
        end
      end
    end
    @(negedge clk);
    idle_inputs();
    #1;
    vectors++;
    if (conflict_cnt !== 16'hFFFF) begin
      miscompares++; $display("FAIL sat_hold got %h exp ffff", conflict_cnt);
    end
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    test_reset();
    test_fetch_only();
    test_store_load();
    test_conflict();
    test_strict_priority();
    test_reset_mid_read();
    test_wrap();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
